// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, sub-word load extraction and write-back select.
// Optional build macro: MISALIGN_TRAP_EN adds a misalign output and trap.
module mem_wb_stage #(
  parameter int B     = 32,
  parameter int W     = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_valid,
  input  logic [B-1:0]     alu_result,
  input  logic [B-1:0]     mem_rdata,
  input  logic             reg_write_in,
  input  logic             mem_to_reg_in,
  input  logic [W-1:0]     write_reg_in,
  input  logic [2:0]       load_type_in,
  input  logic             stall,
  input  logic             flush,
  output logic [B-1:0]     wb_data,
  output logic [W-1:0]     wb_reg,
  output logic             wb_reg_write,
  output logic             wb_valid,
  output logic [CNT_W-1:0] retired_count
`ifdef MISALIGN_TRAP_EN
  ,
  output logic             misalign
`endif
);

  typedef struct packed {
    logic         valid;
    logic [B-1:0] alu;
    logic [1:0]   off;
    logic [2:0]   lt;
    logic         m2r;
    logic [W-1:0] wreg;
    logic         rw;
  } mw_t;

  mw_t              mw_q, mw_d;
  logic             hold_q;
  logic [B-1:0]     hold_data_q;
  logic [CNT_W-1:0] cnt_q;

  logic             is_lh, is_lhu, is_lb, is_lbu, is_lw;
  logic [15:0]      half;
  logic [7:0]       bsel;
  logic [B-1:0]     ext;
  logic [B-1:0]     load_val;
  logic             mis;
  logic             retire;

  always_comb begin
    mw_d = mw_q;
    if (flush) begin
      mw_d.valid = 1'b0;
      mw_d.rw    = 1'b0;
    end else if (!stall) begin
      mw_d.valid = mem_valid;
      mw_d.alu   = alu_result;
      mw_d.off   = alu_result[1:0];
      mw_d.lt    = load_type_in;
      mw_d.m2r   = mem_to_reg_in;
      mw_d.wreg  = write_reg_in;
      mw_d.rw    = reg_write_in;
    end
  end

  assign is_lh  = (mw_q.lt == 3'b001);
  assign is_lhu = (mw_q.lt == 3'b010);
  assign is_lb  = (mw_q.lt == 3'b011);
  assign is_lbu = (mw_q.lt == 3'b100);
  assign is_lw  = ~(is_lh | is_lhu | is_lb | is_lbu);

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    half = mw_q.off[1] ? mem_rdata[15:0]
                       : mem_rdata[B-1 -: 16];
    unique case (mw_q.off)
      2'd0:    bsel = mem_rdata[B-1  -: 8];
      2'd1:    bsel = mem_rdata[B-9  -: 8];
      2'd2:    bsel = mem_rdata[B-17 -: 8];
      default: bsel = mem_rdata[B-25 -: 8];
    endcase
  end

  always_comb begin
    ext = mem_rdata;
    unique case (1'b1)
      is_lh:   ext = {{(B-16){half[15]}}, half};
      is_lhu:  ext = {{(B-16){1'b0}}, half};
      is_lb:   ext = {{(B-8){bsel[7]}}, bsel};
      is_lbu:  ext = {{(B-8){1'b0}}, bsel};
      default: ext = mem_rdata;
    endcase
  end

  assign load_val = hold_q ? hold_data_q : ext;

`ifdef MISALIGN_TRAP_EN
  assign mis = mw_q.valid & mw_q.m2r &
               ((is_lw & (mw_q.off != 2'd0)) |
                ((is_lh | is_lhu) & mw_q.off[0]));
  assign misalign = mis;
`else
  assign mis = 1'b0;
`endif

  assign retire = mw_q.valid & ~stall & ~mis;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mw_q        <= '0;
      hold_q      <= 1'b0;
      hold_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      mw_q <= mw_d;
      // RAM output may move during a stall, so freeze the load value.
      if (flush || !stall) begin
        hold_q <= 1'b0;
      end else if (!hold_q) begin
        hold_q      <= 1'b1;
        hold_data_q <= ext;
      end
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign wb_data       = mw_q.m2r ? load_val : mw_q.alu;
  assign wb_reg        = mw_q.wreg;
  assign wb_reg_write  = mw_q.valid & mw_q.rw & ~mis;
  assign wb_valid      = mw_q.valid;
  assign retired_count = cnt_q;

endmodule
